// File: rtl/sbox_fill.sv
// S-array initialiser: fills a 2**ADDR_W x DATA_W synchronous RAM with an identity, reversed or constant pattern.
// Optional read-back verify pass is compiled in with `define SBOX_FILL_VERIFY_EN.
module sbox_fill #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_val,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
    input  logic [DATA_W-1:0] rddata,
    output logic              err
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [1:0] MODE_REV   = 2'b01;
    localparam logic [1:0] MODE_CONST = 2'b10;
    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
`ifdef SBOX_FILL_VERIFY_EN
    localparam logic [ADDR_W:0] END_IDX = {1'b1, {ADDR_W{1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL
`ifdef SBOX_FILL_VERIFY_EN
        , ST_VERIFY
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   wrdata_q, wrdata_d;
    logic                wren_q, wren_d;
    logic                rdy_q, rdy_d;
`ifdef SBOX_FILL_VERIFY_EN
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   chk_addr;
`else
    logic                unused_rddata;
`endif

    // Address is zero-extended or truncated to the word width; reversed is DEPTH-1-a == ~a.
    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] fv,
        input logic [ADDR_W-1:0] a
    );
        logic [MAX_W-1:0]  ext;
        logic [ADDR_W-1:0] src;
        ext = '0;
        if (m == MODE_CONST) begin
            ext[DATA_W-1:0] = fv;
        end else begin
            src = (m == MODE_REV) ? ~a : a;
            ext[ADDR_W-1:0] = src;
        end
        return ext[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mode_q   <= '0;
            fill_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
            rdy_q    <= 1'b1;
`ifdef SBOX_FILL_VERIFY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            fill_q   <= fill_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            rdy_q    <= rdy_d;
`ifdef SBOX_FILL_VERIFY_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        wrdata_d = wrdata_q;
        wren_d   = wren_q;
        rdy_d    = rdy_q;
`ifdef SBOX_FILL_VERIFY_EN
        err_d    = err_q;
        chk_addr = cnt_q[ADDR_W-1:0] - ADDR_W'(1);
`endif
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d  = ST_FILL;
                    cnt_d    = '0;
                    mode_d   = mode;
                    fill_d   = fill_val;
                    wrdata_d = pattern(mode, fill_val, '0);
                    wren_d   = 1'b1;
                    rdy_d    = 1'b0;
`ifdef SBOX_FILL_VERIFY_EN
                    err_d    = 1'b0;
`endif
                end
            end
            ST_FILL: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d    = '0;
                    wren_d   = 1'b0;
                    wrdata_d = '0;
`ifdef SBOX_FILL_VERIFY_EN
                    state_d  = ST_VERIFY;
`else
                    state_d  = ST_IDLE;
                    rdy_d    = 1'b1;
`endif
                end else begin
                    cnt_d    = cnt_q + (ADDR_W+1)'(1);
                    wrdata_d = pattern(mode_q, fill_q, cnt_d[ADDR_W-1:0]);
                end
            end
`ifdef SBOX_FILL_VERIFY_EN
            // rddata seen at count c belongs to the address presented at c-1; the extra count drains the last read.
            ST_VERIFY: begin
                if ((cnt_q != '0) && (rddata != pattern(mode_q, fill_q, chk_addr))) begin
                    err_d = 1'b1;
                end
                if (cnt_q == END_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                wren_d  = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    assign addr   = cnt_q[ADDR_W-1:0];
    assign wrdata = wrdata_q;
    assign wren   = wren_q;
    assign rdy    = rdy_q;
`ifdef SBOX_FILL_VERIFY_EN
    assign err    = err_q;
`else
    assign unused_rddata = ^rddata;
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_sbox_fill.sv
// Directed bench for sbox_fill: 256x8 instance plus a 16x8 instance, each with a behavioural synchronous RAM.
module tb_sbox_fill;

`ifdef SBOX_FILL_VERIFY_EN
    localparam int LOWB = 513;
    localparam int LOWS = 33;
    localparam logic ERR_BAD = 1'b1;
`else
    localparam int LOWB = 256;
    localparam int LOWS = 16;
    localparam logic ERR_BAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] fill_val = 8'h00;
    logic       rdy, wren, err;
    logic [7:0] addr, wrdata, rddata;

    logic       s_en = 1'b0;
    logic [1:0] s_mode = 2'b00;
    logic [7:0] s_fill = 8'h00;
    logic       s_rdy, s_wren, s_err;
    logic [3:0] s_addr;
    logic [7:0] s_wrdata, s_rddata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sbox_fill #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .mode(mode), .fill_val(fill_val),
        .addr(addr), .wrdata(wrdata), .wren(wren), .rddata(rddata), .err(err)
    );

    sbox_fill #(.ADDR_W(4), .DATA_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(s_en), .rdy(s_rdy), .mode(s_mode), .fill_val(s_fill),
        .addr(s_addr), .wrdata(s_wrdata), .wren(s_wren), .rddata(s_rddata), .err(s_err)
    );

    // Memory models; corrupt77 flips bit 0 of whatever is written to word 77.
    logic [7:0] mem [0:255];
    logic [7:0] s_mem [0:15];
    logic       corrupt77 = 1'b0;

    always @(posedge clk) begin
        if (wren) mem[addr] <= (corrupt77 && addr == 8'd77) ? (wrdata ^ 8'h01) : wrdata;
        rddata <= mem[addr];
    end

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata <= s_mem[s_addr];
    end

    // Write-stream monitors: a run must start at address 0 and step by one.
    logic       prev_wren = 1'b0, s_prev_wren = 1'b0;
    logic [7:0] last_a = 8'd0;
    logic [3:0] s_last_a = 4'd0;
    int wr_total = 0, seq_bad = 0, s_wr_total = 0, s_seq_bad = 0;

    always @(posedge clk) begin
        if (wren) begin
            wr_total++;
            if (addr !== (prev_wren ? last_a + 8'd1 : 8'd0)) seq_bad++;
            last_a = addr;
        end
        prev_wren = wren;
        if (s_wren) begin
            s_wr_total++;
            if (s_addr !== (s_prev_wren ? s_last_a + 4'd1 : 4'd0)) s_seq_bad++;
            s_last_a = s_addr;
        end
        s_prev_wren = s_wren;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bad_big(input logic [1:0] m, input logic [7:0] fv);
        int bad = 0;
        logic [7:0] e;
        for (int i = 0; i < 256; i++) begin
            if (m == 2'b01) e = 8'(255 - i);
            else if (m == 2'b10) e = fv;
            else e = 8'(i);
            if (mem[i] !== e) bad++;
        end
        return bad;
    endfunction

    // Starts a run on the large instance and returns how many cycles rdy stayed low.
    task automatic run_big(input logic [1:0] m, input logic [7:0] fv, input logic [7:0] exp_w0, output int low);
        @(negedge clk);
        mode = m; fill_val = fv; en = 1'b1;
        @(posedge clk); #1;
        chk("acc_rdy", rdy, 0);
        chk("acc_wren", wren, 1);
        chk("acc_addr", addr, 0);
        chk("acc_wrdata", wrdata, exp_w0);
        chk("acc_err", err, 0);
        @(negedge clk);
        en = 1'b0;
        low = 1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (rdy) break;
            low++;
        end
    endtask

    task automatic run_small(input logic [1:0] m, input logic [7:0] fv, input logic [7:0] exp_w0, output int low);
        @(negedge clk);
        s_mode = m; s_fill = fv; s_en = 1'b1;
        @(posedge clk); #1;
        chk("s_acc_wren", s_wren, 1);
        chk("s_acc_wrdata", s_wrdata, exp_w0);
        @(negedge clk);
        s_en = 1'b0;
        low = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (s_rdy) break;
            low++;
        end
    endtask

    initial begin
        int low, w0, q0, bad;

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 16; i++) s_mem[i] = 8'hEE;

        // Asynchronous reset asserted mid-cycle.
        #12 rst_n = 1'b0;
        #1;
        chk("rst_rdy", rdy, 1);
        chk("rst_wren", wren, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_err", err, 0);
        chk("rst_s_rdy", s_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_wren", wren, 0);

        // Identity fill.
        w0 = wr_total; q0 = seq_bad;
        run_big(2'b00, 8'h00, 8'h00, low);
        chk("id_rdy_low", low, LOWB);
        chk("id_writes", wr_total - w0, 256);
        chk("id_seq", seq_bad - q0, 0);
        chk("id_mem_bad", bad_big(2'b00, 8'h00), 0);
        chk("id_mem255", mem[255], 8'hFF);
        chk("id_end_wren", wren, 0);
        chk("id_end_addr", addr, 0);
        chk("id_end_err", err, 0);

        // Mode 11 behaves as identity; start from a scrubbed memory.
        for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
        run_big(2'b11, 8'h99, 8'h00, low);
        chk("m11_rdy_low", low, LOWB);
        chk("m11_mem_bad", bad_big(2'b00, 8'h00), 0);

        // Reversed on the 256-word instance.
        run_big(2'b01, 8'h00, 8'hFF, low);
        chk("rev_rdy_low", low, LOWB);
        chk("rev_mem_bad", bad_big(2'b01, 8'h00), 0);

        // Constant with fill_val and mode changed mid-run.
        w0 = wr_total;
        fork
            run_big(2'b10, 8'hA5, 8'hA5, low);
            begin
                repeat (100) @(negedge clk);
                fill_val = 8'h3C;
                mode = 2'b00;
            end
        join
        chk("const_rdy_low", low, LOWB);
        chk("const_writes", wr_total - w0, 256);
        chk("const_mem_bad", bad_big(2'b10, 8'hA5), 0);

        // en pulsed mid-run is ignored.
        w0 = wr_total; q0 = seq_bad;
        fork
            run_big(2'b00, 8'h00, 8'h00, low);
            begin
                for (int i = 0; i < 1000 && addr !== 8'd50; i++) @(negedge clk);
                chk("reach_addr50", addr, 50);
                en = 1'b1;
                @(negedge clk);
                en = 1'b0;
            end
        join
        chk("enmid_rdy_low", low, LOWB);
        chk("enmid_writes", wr_total - w0, 256);
        chk("enmid_seq", seq_bad - q0, 0);
        repeat (3) @(negedge clk);
        chk("enmid_no_restart", rdy, 1);

        // Reset at addr 100 aborts; a fresh run refills from 0.
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        @(negedge clk);
        mode = 2'b00; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 1000 && addr !== 8'd100; i++) @(negedge clk);
        chk("reach_addr100", addr, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wren", wren, 0);
        chk("abort_rdy", rdy, 1);
        chk("abort_addr", addr, 0);
        chk("abort_mem_untouched", mem[200], 8'hEE);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_total; q0 = seq_bad;
        run_big(2'b00, 8'h00, 8'h00, low);
        chk("refill_rdy_low", low, LOWB);
        chk("refill_writes", wr_total - w0, 256);
        chk("refill_seq", seq_bad - q0, 0);
        chk("refill_mem_bad", bad_big(2'b00, 8'h00), 0);

        // Corrupted word 77: err raised only by the verify pass, then cleared by the next start.
        corrupt77 = 1'b1;
        run_big(2'b00, 8'h00, 8'h00, low);
        chk("bad77_rdy_low", low, LOWB);
        chk("bad77_err", err, ERR_BAD);
        chk("bad77_mem77", mem[77], 8'h4C);
        corrupt77 = 1'b0;
        run_big(2'b00, 8'h00, 8'h00, low);
        chk("clean_err", err, 0);

        // Reversed on the 16-word instance (address zero-extended into 8 bits).
        w0 = s_wr_total; q0 = s_seq_bad;
        run_small(2'b01, 8'h00, 8'h0F, low);
        chk("s_rev_rdy_low", low, LOWS);
        chk("s_rev_writes", s_wr_total - w0, 16);
        chk("s_rev_seq", s_seq_bad - q0, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (s_mem[i] !== 8'(15 - i)) bad++;
        chk("s_rev_mem_bad", bad, 0);
        chk("s_rev_mem0", s_mem[0], 8'h0F);
        chk("s_rev_err", s_err, 0);

        // en held high: runs restart after exactly one rdy=1 cycle.
        @(negedge clk);
        s_mode = 2'b00; s_en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 200 && !s_rdy; i++) begin
            @(posedge clk); #1;
        end
        chk("b2b_rdy_gap", s_rdy, 1);
        @(posedge clk); #1;
        chk("b2b_restart_rdy", s_rdy, 0);
        chk("b2b_restart_wren", s_wren, 1);
        chk("b2b_restart_addr", s_addr, 0);
        @(negedge clk);
        s_en = 1'b0;
        low = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (s_rdy) break;
            low++;
        end
        chk("b2b_rdy_low", low, LOWS);
        bad = 0;
        for (int i = 0; i < 16; i++) if (s_mem[i] !== 8'(i)) bad++;
        chk("b2b_mem_bad", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
